// File: rtl/deconv_gf2_serial_pkg.sv
// rtl/deconv_gf2_serial_pkg.sv - shared types and width helper for the GF(2) serial deconvolver
package deconv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FILL,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Full-convolution result width, shared with the convolver side.
    function automatic int conv_out_w(input int in_w, input int k_w);
        return in_w + k_w - 1;
    endfunction

endpackage

// File: rtl/gf2_div_step.sv
// rtl/gf2_div_step.sv - one LFSR long-division step over GF(2)
module gf2_div_step #(
    parameter int K_W = 3
) (
    input  logic [K_W-2:0] s,
    input  logic           b,
    input  logic [K_W-2:0] kreg,
    output logic [K_W-2:0] s_next,
    output logic           q
);

    logic [K_W-1:0] t;

    // The leading kernel coefficient is always 1, so it only decides q and is never stored.
    assign t      = {s, b};
    assign q      = t[K_W-1];
    assign s_next = t[K_W-2:0] ^ ({(K_W-1){q}} & kreg);

endmodule

// File: rtl/deconv_gf2_serial.sv
// rtl/deconv_gf2_serial.sv - serial GF(2) deconvolver: dividend bits in, quotient bits and word out
module deconv_gf2_serial
    import deconv_pkg::*;
#(
    parameter int IN_W = 255,
    parameter int K_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [K_W-1:0]  kernel,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_data,
    output logic            m_last,
    output logic [IN_W-1:0] quot,
    output logic [K_W-2:0]  rem,
    output logic            rem_ok,
    output logic            err_kernel,
    output logic            busy,
    output logic            done
);

    localparam int OUT_W = conv_out_w(IN_W, K_W);
    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] FILL_END = CNT_W'(K_W - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W);

    state_t           state;
    state_t           state_nx;
    logic [K_W-1:0]   kreg;
    logic [K_W-2:0]   sreg;
    logic [K_W-2:0]   s_next;
    logic             q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             s_acc;

    gf2_div_step #(.K_W(K_W)) u_step (
        .s      (sreg),
        .b      (s_data),
        .kreg   (kreg[K_W-2:0]),
        .s_next (s_next),
        .q      (q)
    );

    assign s_acc   = s_valid && s_ready;
    assign cnt_inc = (cnt == LAST_CNT) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_CHECK;
            ST_CHECK: state_nx = kreg[K_W-1] ? ST_FILL : ST_DONE;
            ST_FILL:  if (s_acc && cnt_inc == FILL_END) state_nx = ST_RUN;
            ST_RUN:   if (s_acc && cnt_inc == LAST_CNT) state_nx = ST_FLUSH;
            ST_FLUSH: if (!m_valid || m_ready) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // RUN keeps accepting while the single output slot is empty or draining this cycle.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_FILL: s_ready = 1'b1;
            ST_RUN:  s_ready = !m_valid || m_ready;
            default: s_ready = 1'b0;
        endcase
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kreg       <= '0;
            sreg       <= '0;
            cnt        <= '0;
            m_valid    <= 1'b0;
            m_data     <= 1'b0;
            m_last     <= 1'b0;
            quot       <= '0;
            rem        <= '0;
            rem_ok     <= 1'b0;
            err_kernel <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        kreg       <= kernel;
                        err_kernel <= 1'b0;
                        rem        <= '0;
                        rem_ok     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    sreg <= '0;
                    quot <= '0;
                    cnt  <= '0;
                    if (!kreg[K_W-1]) err_kernel <= 1'b1;
                end
                ST_FILL: begin
                    if (s_acc) begin
                        sreg <= s_next;
                        cnt  <= cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (s_acc) begin
                        sreg    <= s_next;
                        cnt     <= cnt_inc;
                        m_valid <= 1'b1;
                        m_data  <= q;
                        m_last  <= (cnt_inc == LAST_CNT);
                        quot    <= IN_W'({quot, q});
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (!m_valid || m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        rem     <= sreg;
                        rem_ok  <= (sreg == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deconv_gf2_serial.sv
// tb/tb_deconv_gf2_serial.sv - directed-vector bench for deconv_gf2_serial
module tb_deconv_gf2_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    // Short configuration: IN_W=4, K_W=3
    logic       sm_start = 0, sm_s_valid = 0, sm_s_data = 0, sm_m_ready = 1;
    logic [2:0] sm_kernel = 0;
    logic       sm_s_ready, sm_m_valid, sm_m_data, sm_m_last;
    logic [3:0] sm_quot;
    logic [1:0] sm_rem;
    logic       sm_rem_ok, sm_err_kernel, sm_busy, sm_done;

    deconv_gf2_serial #(.IN_W(4), .K_W(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(sm_start), .kernel(sm_kernel),
        .s_valid(sm_s_valid), .s_ready(sm_s_ready), .s_data(sm_s_data),
        .m_valid(sm_m_valid), .m_ready(sm_m_ready), .m_data(sm_m_data), .m_last(sm_m_last),
        .quot(sm_quot), .rem(sm_rem), .rem_ok(sm_rem_ok), .err_kernel(sm_err_kernel),
        .busy(sm_busy), .done(sm_done)
    );

    // Default configuration: IN_W=255, K_W=3
    logic         bg_start = 0, bg_s_valid = 0, bg_s_data = 0, bg_m_ready = 1;
    logic [2:0]   bg_kernel = 0;
    logic         bg_s_ready, bg_m_valid, bg_m_data, bg_m_last;
    logic [254:0] bg_quot;
    logic [1:0]   bg_rem;
    logic         bg_rem_ok, bg_err_kernel, bg_busy, bg_done;

    deconv_gf2_serial u_big (
        .clk(clk), .rst_n(rst_n), .start(bg_start), .kernel(bg_kernel),
        .s_valid(bg_s_valid), .s_ready(bg_s_ready), .s_data(bg_s_data),
        .m_valid(bg_m_valid), .m_ready(bg_m_ready), .m_data(bg_m_data), .m_last(bg_m_last),
        .quot(bg_quot), .rem(bg_rem), .rem_ok(bg_rem_ok), .err_kernel(bg_err_kernel),
        .busy(bg_busy), .done(bg_done)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_small(input string name, input logic [5:0] stream, input logic [2:0] ker,
                             input logic [3:0] eq, input logic [1:0] er, input logic eok,
                             input logic eerr, input int stall_beat, input int abort_at);
        int   sent, got, stall_cnt, last_hs, done_cyc;
        logic seen_done, saw_sready, stalling, abort_done;
        sent = 0; got = 0; stall_cnt = 0; last_hs = -10; done_cyc = -10;
        seen_done = 0; saw_sready = 0; abort_done = 0;
        @(negedge clk);
        sm_kernel = ker;
        sm_start  = 1'b1;
        for (int cyc = 1; cyc <= 60 && !seen_done; cyc++) begin
            @(negedge clk);
            sm_start   = 1'b0;
            sm_s_valid = eerr || (sent < 6);
            sm_s_data  = (sent < 6) ? stream[5-sent] : 1'b0;
            stalling   = sm_m_valid && (got == stall_beat) && (stall_cnt < 3);
            sm_m_ready = !stalling;
            #1;
            if (abort_at >= 0 && got == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({name, "_abort_outs"},
                      256'({sm_s_ready, sm_m_valid, sm_m_data, sm_m_last, sm_busy, sm_done,
                            sm_err_kernel, sm_rem_ok, sm_rem, sm_quot}), 256'd0);
                repeat (3) begin
                    @(negedge clk);
                    if (sm_done) abort_done = 1'b1;
                end
                check({name, "_abort_no_done"}, 256'(abort_done), 256'd0);
                sm_s_valid = 1'b0;
                sm_m_ready = 1'b1;
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (sm_s_ready) saw_sready = 1'b1;
            if (sm_done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end else begin
                if (stalling) begin
                    check({name, "_stall_s_ready"}, 256'(sm_s_ready), 256'd0);
                    if (got < 4) check({name, "_stall_hold"}, 256'(sm_m_data), 256'(eq[3-got]));
                    stall_cnt++;
                end
                if (sm_s_valid && sm_s_ready) sent++;
                if (sm_m_valid && sm_m_ready) begin
                    if (got < 4) check({name, "_beat"}, 256'(sm_m_data), 256'(eq[3-got]));
                    check({name, "_last"}, 256'(sm_m_last), 256'(got == 3));
                    got++;
                    last_hs = cyc;
                end
            end
        end
        check({name, "_done_seen"}, 256'(seen_done), 256'd1);
        if (seen_done) begin
            check({name, "_quot"}, 256'(sm_quot), 256'(eq));
            check({name, "_rem"}, 256'(sm_rem), 256'(er));
            check({name, "_rem_ok"}, 256'(sm_rem_ok), 256'(eok));
            check({name, "_err"}, 256'(sm_err_kernel), 256'(eerr));
            if (eerr) begin
                check({name, "_done_lat"}, 256'(done_cyc), 256'd2);
                check({name, "_no_s_ready"}, 256'(saw_sready), 256'd0);
            end else begin
                check({name, "_beats"}, 256'(got), 256'd4);
                check({name, "_done_after_last"}, 256'(done_cyc), 256'(last_hs + 1));
            end
        end
        sm_s_valid = 1'b0;
        sm_m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_big();
        logic [254:0] in_word;
        logic [256:0] dv;
        logic [254:0] rx;
        int           sent, got, last_at;
        logic         seen_done;
        in_word = 255'b011010101010110001111;
        dv = {2'b00, in_word} ^ ({2'b00, in_word} << 2);
        rx = '0; sent = 0; got = 0; last_at = -1; seen_done = 0;
        @(negedge clk);
        bg_kernel = 3'b101;
        bg_start  = 1'b1;
        for (int cyc = 1; cyc <= 4000 && !seen_done; cyc++) begin
            @(negedge clk);
            bg_start   = 1'b0;
            bg_s_valid = (sent < 257) && ($urandom_range(0, 3) != 0);
            bg_s_data  = (sent < 257) ? dv[256-sent] : 1'b0;
            bg_m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bg_done) begin
                seen_done = 1'b1;
            end else begin
                if (bg_s_valid && bg_s_ready) sent++;
                if (bg_m_valid && bg_m_ready) begin
                    rx = {rx[253:0], bg_m_data};
                    got++;
                    if (bg_m_last) last_at = got;
                end
            end
        end
        check("big_done_seen", 256'(seen_done), 256'd1);
        check("big_beats", 256'(got), 256'd255);
        check("big_last_pos", 256'(last_at), 256'd255);
        check("big_stream", 256'(rx), 256'(in_word));
        check("big_quot", 256'(bg_quot), 256'(in_word));
        check("big_rem_ok", 256'(bg_rem_ok), 256'd1);
        bg_s_valid = 1'b0;
        bg_m_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_small", 256'({sm_s_ready, sm_m_valid, sm_m_data, sm_m_last, sm_busy, sm_done,
                                 sm_err_kernel, sm_rem_ok, sm_rem, sm_quot}), 256'd0);
        check("rst_big", 256'({bg_s_ready, bg_m_valid, bg_m_data, bg_m_last, bg_busy, bg_done,
                               bg_err_kernel, bg_rem_ok, bg_rem, bg_quot}), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_small("t1_exact",   6'b100111, 3'b101, 4'b1011, 2'b00, 1'b1, 1'b0, -1, -1);
        run_small("t2_rem",     6'b100110, 3'b101, 4'b1011, 2'b01, 1'b0, 1'b0, -1, -1);
        run_small("t3_badker",  6'b100111, 3'b011, 4'b0000, 2'b00, 1'b0, 1'b1, -1, -1);
        run_small("t4_stall",   6'b100111, 3'b101, 4'b1011, 2'b00, 1'b1, 1'b0, 1, -1);
        run_small("t6_abort",   6'b100111, 3'b101, 4'b1011, 2'b00, 1'b1, 1'b0, -1, 2);
        run_small("t6_restart", 6'b100111, 3'b101, 4'b1011, 2'b00, 1'b1, 1'b0, -1, -1);
        run_big();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
